// File: rtl/pipeline_types.sv
// Shared types for the measurement control path: control-path strobes,
// period-sequencer FSM state and the packed period result.
package pipeline_types;

    localparam int unsigned PERIOD_COUNT_WIDTH = 16;

    typedef struct packed {
        logic rising;
        logic falling;
    } control_path_t;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        MEASURE,
        HOLD
    } period_state_t;

    typedef struct packed {
        logic [PERIOD_COUNT_WIDTH-1:0] count;
        logic                          timeout;
    } period_result_t;

endpackage

// File: rtl/period_sequencer.sv
// Period measurement controller: counts divider ticks between two rising
// control edges and hands the result out on a valid/ready handshake.
module period_sequencer
    import pipeline_types::*;
#(
    parameter int unsigned COUNT_WIDTH   = PERIOD_COUNT_WIDTH,
    parameter int unsigned TIMEOUT_TICKS = 1000
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  control_path_t  i_control,
    input  logic           i_count_enable,
    input  logic           i_arm,
    input  logic           i_abort,
    input  logic           i_continuous,
    input  logic           i_ready,
    output logic           o_valid,
    output period_result_t o_result,
    output logic           o_busy,
    output logic           o_overrun
);

    if (COUNT_WIDTH < 1 || COUNT_WIDTH > PERIOD_COUNT_WIDTH) begin : g_bad_width
        $error("period_sequencer: COUNT_WIDTH out of range");
    end
    if (TIMEOUT_TICKS < 1 ||
        longint'(TIMEOUT_TICKS) > ((longint'(1) << COUNT_WIDTH) - 1)) begin : g_bad_timeout
        $error("period_sequencer: TIMEOUT_TICKS out of range");
    end

    localparam logic [COUNT_WIDTH-1:0] LP_TIMEOUT = COUNT_WIDTH'(TIMEOUT_TICKS);

    period_state_t          r_state;
    period_state_t          w_state_next;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] w_count_inc;
    period_result_t         r_result;
    logic                   r_overrun;
    logic                   w_rise;
    logic                   w_timeout_hit;
    logic                   w_unused_control;

    assign w_rise           = i_control.rising;
    assign w_unused_control = i_control.falling;
    assign w_count_inc      = r_count + COUNT_WIDTH'(i_count_enable);
    assign w_timeout_hit    = (w_count_inc == LP_TIMEOUT);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Abort overrides every other transition, including a pending handshake.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_arm) w_state_next = ARMED;
            ARMED:   if (w_rise) w_state_next = MEASURE;
            MEASURE: if (w_rise || w_timeout_hit) w_state_next = HOLD;
            HOLD:    if (i_ready) w_state_next = i_continuous ? ARMED : IDLE;
            default: w_state_next = IDLE;
        endcase
        if (i_abort) begin
            w_state_next = IDLE;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count   <= '0;
            r_result  <= '0;
            r_overrun <= 1'b0;
        end else if (!i_abort) begin
            case (r_state)
                IDLE: begin
                    if (i_arm) r_overrun <= 1'b0;
                end
                ARMED: begin
                    if (w_rise) r_count <= '0;
                end
                MEASURE: begin
                    r_count <= w_count_inc;
                    // A closing edge outranks a timeout reached on the same tick.
                    if (w_rise) begin
                        r_result.count   <= PERIOD_COUNT_WIDTH'(w_count_inc);
                        r_result.timeout <= 1'b0;
                    end else if (w_timeout_hit) begin
                        r_result.count   <= PERIOD_COUNT_WIDTH'(LP_TIMEOUT);
                        r_result.timeout <= 1'b1;
                    end
                end
                HOLD: begin
                    if (w_rise) r_overrun <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_valid   = (r_state == HOLD);
        o_busy    = (r_state == ARMED) || (r_state == MEASURE);
        o_result  = r_result;
        o_overrun = r_overrun;
    end

endmodule

// File: doc/period_sequencer.md
# period_sequencer

Measurement controller sitting between the control path and the clock-enable divider. It arms on request, opens a measurement window on one `i_control.rising` event and closes it on the next. It counts divider ticks (`i_count_enable`) inside the window and presents the result on a valid/ready handshake, with timeout and overrun flagging. It sequences the counting datapath only; tick generation stays in the divider.

## Interface
- `COUNT_WIDTH`, 16: width of tick count and result.
- `TIMEOUT_TICKS`, 1000: tick count at which a window is force-closed; legal range 1 .. 2^COUNT_WIDTH-1, checked at elaboration.
- `i_clk`  in  1  clock; single clock domain.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_control`  in  `pipeline_types::control_path_t`  control path; only `.rising` is used.
- `i_count_enable`  in  1  divider tick, one-cycle pulses.
- `i_arm`  in  1  pulse; starts a measurement from IDLE.
- `i_abort`  in  1  pulse; cancels from any state.
- `i_continuous`  in  1  1 = re-arm automatically after each handshake; sampled at handshake.
- `i_ready`  in  1  consumer ready.
- `o_valid`  out  1  result valid.
- `o_result`  out  `pipeline_types::period_result_t`  {count[COUNT_WIDTH], timeout}.
- `o_busy`  out  1  high in ARMED or MEASURE.
- `o_overrun`  out  1  sticky; a rising edge arrived while in HOLD.

## Operation
- States: IDLE, ARMED, MEASURE, HOLD.
- IDLE: `i_arm` -> ARMED, clear `o_overrun`. Rising edges and ticks are ignored.
- ARMED: `i_control.rising` -> MEASURE, clear the tick counter to 0. Ticks are ignored.
- MEASURE: each `i_count_enable` increments the counter. Terminating conditions, in priority order:
  - `i_control.rising`: latch count (including any tick in the same cycle), set timeout=0, go to HOLD.
  - Counter reaches `TIMEOUT_TICKS`: latch count=`TIMEOUT_TICKS`, set timeout=1, go to HOLD.
- The counter never exceeds `TIMEOUT_TICKS`, so no wrap-around is possible.
- HOLD: `o_valid`=1 and `o_result` is stable until the handshake (`o_valid && i_ready`). On the handshake:
  - `i_continuous`=1 -> ARMED.
  - `i_continuous`=0 -> IDLE.
- A rising edge in HOLD sets `o_overrun`. It does not start a window.
- `i_abort` in any state -> IDLE: drops `o_valid`, and no transfer completes even if `i_ready` is high. Abort wins over arm, rising, timeout and handshake in the same cycle.
- `i_arm` outside IDLE is ignored.

## Timing
- Reset values: state IDLE, `o_valid` 0, `o_result` all-zero, `o_busy` 0, `o_overrun` 0.
- All outputs are registered; there are no combinational input-to-output paths.
- `o_valid` rises 1 cycle after the terminating rising edge or timeout-reaching tick.
- `o_busy` rises 1 cycle after `i_arm`.
- After a handshake in cycle N:
  - `o_valid` is 0 in cycle N+1.
  - In continuous mode, ARMED is entered in N+1. A rising edge in cycle N+1 is accepted as a window start; a rising edge in cycle N counts as overrun.
- Back-to-back windows therefore need a rising edge after the handshake. Consecutive edges are never shared between windows.
- A reset asserted mid-window returns to IDLE immediately, with outputs at reset values; no partial result is emitted.

## Structure
- In `pipeline_types`: `period_state_t` enum (IDLE, ARMED, MEASURE, HOLD) and `period_result_t` packed struct {logic [COUNT_WIDTH-1:0] count; logic timeout;}. The default width comes from a package constant `PERIOD_COUNT_WIDTH` = 16.
- Single flat module: one FSM always_ff, one counter, one result register. No sub-module; the tick counter is too small to justify one.

## Test plan
Bench uses COUNT_WIDTH=8, TIMEOUT_TICKS=8, divider tick every 5 cycles.
- Basic: arm, rising at t0, 3 ticks, rising -> `o_valid` next cycle, count=3, timeout=0. With `i_ready`=1 and `i_continuous`=0, the FSM returns to IDLE and `o_busy`=0.
- Same-cycle: rising coincident with the 4th tick -> count=4. Rising coincident with the tick that reaches 8 -> count=8, timeout=0.
- Timeout: arm, rising, no second rising -> after 8th tick `o_valid`, count=8, timeout=1.
- Backpressure/overrun: hold `i_ready`=0 for 20 cycles while 2 rising edges arrive -> `o_result` stable, `o_overrun`=1. Release ready with continuous=1 -> ARMED; `o_overrun` stays 1 until the next `i_arm` from IDLE.
- Abort/reset: abort in MEASURE, and abort with `i_ready`=1 in HOLD -> IDLE, `o_valid`=0, no transfer. Async reset mid-MEASURE -> all outputs zero within the same cycle.
